pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the MIPS datapath. Holds the PC, issues word fetches to instruction memory over a req/ack handshake, and computes the next PC from sequential, branch (PC+4 plus a pre-shifted byte offset) or jump targets. It sits at the front of the pipeline and directly consumes the output of the shift-left-by-2 stage on the branch path.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; hold PC and suspend fetching
- branch_taken  in  1  taken-branch redirect, valid this cycle
- jump  in  1  jump redirect, valid this cycle; wins over branch_taken
- redir_pc4  in  32  PC+4 of the redirecting instruction
- branch_offset  in  32  sign-extended offset already shifted left 2 (byte offset)
- jump_index  in  26  instruction[25:0] of the jump
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals pc)
- imem_ack  in  1  memory returned the word for imem_addr this cycle
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational
- fetch_valid  out  1  fetched word is on the correct path, qualifies imem data

## Operation
- States: IDLE, FETCH, STALLED.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, fetch_valid=0, redirect-pending flag=0.
- Targets: branch = redir_pc4 + branch_offset, modulo 2^32 with no overflow flag. Jump = {redir_pc4[31:28], jump_index, 2'b00}. jump has priority over branch_taken.
- IDLE: transition to FETCH unconditionally on the next cycle. A redirect in IDLE loads pc directly.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On ack with no pending redirect and no redirect this cycle: fetch_valid=1 and pc <= pc_plus4.
  - On ack with pending redirect or a redirect this cycle: fetch_valid=0, which squashes the wrong-path word. pc <= redirect target, and the pending flag clears.
  - A redirect without ack latches the target and sets the pending flag. imem_addr stays stable until ack, so the request is never withdrawn.
  - A later redirect before ack overwrites the pending target; the last one wins.
  - stall=1 with ack: the update above happens first, then the state moves to STALLED. stall=1 without ack: remain in FETCH until ack, then go to STALLED.
- STALLED:
  - imem_req=0, fetch_valid=0, pc held.
  - A redirect loads pc immediately and stays in STALLED.
  - When stall deasserts, go to FETCH.
- rst_n asserted mid-fetch: all registers clear asynchronously and imem_req drops at once. An ack arriving during reset is ignored.

## Timing
- imem_req rises one cycle after rst_n deasserts.
- Minimum fetch latency: ack in the same cycle as req. This gives one word per cycle at full throughput.
- fetch_valid is combinational from imem_ack and state; asserted only in FETCH.
- pc changes only on a clock edge. pc_plus4 and imem_addr follow pc with no extra register stage.
- Redirect to first correct-path fetch: 1 cycle after the squashing ack.

## Structure
- The shared package holds:
  - the state enum (IDLE, FETCH, STALLED)
  - a PC_STEP=4 constant
  - a target-select enum (SEQ, BRANCH, JUMP)
- Natural sub-module: pc_target_calc. It is purely combinational: redir_pc4, branch_offset, jump_index, select in; 32-bit target out.
- The FSM, PC register and pending-redirect register live in pc_fetch_unit.

## Test plan
- Reset release with RESET_PC=0x0040_0000 and ack tied high: pc steps 0x0040_0000, 0x0040_0004, 0x0040_0008. fetch_valid=1 from the second cycle.
- Branch: redir_pc4=0x0040_0010, branch_offset=0xFFFF_FFF0, ack high. The next pc is 0x0040_0000 and that cycle's fetch_valid=0.
- Jump together with branch_taken: redir_pc4=0x1000_0004, jump_index=0x0000_100. pc becomes 0x1000_0400 (jump wins).
- Redirect while ack is low for 3 cycles:
  - imem_addr is unchanged until ack.
  - On ack, fetch_valid=0 and pc takes the latched target.
  - A second redirect during the wait overrides the first.
- Stall for 4 cycles at pc=0x0000_0020: imem_req=0 and pc is held. On release, imem_req=1 and imem_addr=0x0000_0020.
- Wrap and reset: pc=0xFFFF_FFFC sequential gives 0x0000_0000. rst_n pulled low mid-wait drops imem_req immediately, and pc returns to RESET_PC.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
//   fetch_state_t : sequencer states (IDLE, FETCH, STALLED)
//   target_sel_t  : next-PC source select (SEQ, BRANCH, JUMP)
//   PC_STEP       : byte distance between sequential instruction words
package pc_fetch_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STALLED = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2
    } target_sel_t;

endpackage

// File: rtl/pc_target_calc.sv
// Purely combinational redirect-target calculator.
//   redir_pc4     in  32  PC+4 of the redirecting instruction
//   branch_offset in  32  sign-extended, pre-shifted byte offset
//   jump_index    in  26  instruction[25:0] of a jump
//   sel           in      target select (SEQ / BRANCH / JUMP)
//   target        out 32  selected target address
module pc_target_calc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] redir_pc4,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    input  target_sel_t sel,
    output logic [31:0] target
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // target unassigned, which would infer a latch.
        target = redir_pc4;
        unique case (sel)
            // Branch wraps modulo 2^32; no overflow is reported.
            BRANCH:  target = redir_pc4 + branch_offset;
            // Jump stays inside the 256 MB region of the delay-slot PC.
            JUMP:    target = {redir_pc4[31:28], jump_index, 2'b00};
            default: target = redir_pc4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer.
//   clk, rst_n     clock, asynchronous active-low reset
//   stall          hold PC and suspend fetching
//   branch_taken   taken-branch redirect this cycle
//   jump           jump redirect this cycle (wins over branch_taken)
//   redir_pc4      PC+4 of the redirecting instruction
//   branch_offset  pre-shifted byte offset of the branch
//   jump_index     instruction[25:0] of the jump
//   imem_req       fetch request (held until imem_ack)
//   imem_addr      fetch address, equal to pc
//   imem_ack       memory returned the word for imem_addr this cycle
//   pc, pc_plus4   current PC and PC+4
//   fetch_valid    returned word is on the correct path
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [31:0] redir_pc4,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid
);

    fetch_state_t state, state_next;
    target_sel_t  sel;
    logic         redirect;
    logic [31:0]  target;
    logic         pend;         // a redirect arrived while waiting for ack
    logic [31:0]  pend_target;  // most recent such redirect target

    assign redirect = jump | branch_taken;
    assign sel      = jump ? JUMP : (branch_taken ? BRANCH : SEQ);

    pc_target_calc u_target (
        .redir_pc4     (redir_pc4),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .sel           (sel),
        .target        (target)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic. A stall only takes effect once the outstanding
    // fetch has been acknowledged, so the request is never withdrawn.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem_ack && stall) state_next = STALLED;
            STALLED: if (!stall) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; all outputs follow state/pc with no extra register.
    always_comb begin
        imem_req    = (state == FETCH);
        imem_addr   = pc;
        pc_plus4    = pc + PC_STEP;
        // A word returned while a redirect is pending or arriving belongs
        // to the wrong path and is squashed.
        fetch_valid = (state == FETCH) && imem_ack && !pend && !redirect;
    end

    // PC and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_target <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        // A redirect in the ack cycle is newer than any
                        // pending one, so it wins.
                        if (redirect)  pc <= target;
                        else if (pend) pc <= pend_target;
                        else           pc <= pc_plus4;
                        pend <= 1'b0;
                    end else if (redirect) begin
                        pend        <= 1'b1;
                        pend_target <= target;
                    end
                end
                IDLE, STALLED: begin
                    // No fetch outstanding: redirect lands directly.
                    if (redirect) pc <= target;
                end
                default: ;
            endcase
        end
    end

endmodule
